// File: rtl/addsub_pg_pipe_if.sv
// rtl/addsub_pg_pipe_if.sv - operand/result handshake bundle for addsub_pg_pipe
`timescale 1ns/1ps
interface addsub_pg_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             C_OUT;
  logic             OVF;
  logic             ZERO;

  modport master (
    output in_valid, A, B, Sub, out_ready,
    input  in_ready, out_valid, S, C_OUT, OVF, ZERO
  );

  modport slave (
    input  in_valid, A, B, Sub, out_ready,
    output in_ready, out_valid, S, C_OUT, OVF, ZERO
  );
endinterface

// File: rtl/addsub_pg_pipe.sv
// rtl/addsub_pg_pipe.sv - three-stage pipelined adder/subtractor (PG, Kogge-Stone carry, sum)
`timescale 1ns/1ps
module addsub_pg_pipe #(
  parameter int WIDTH = 16
) (
  input  logic            CLK,
  input  logic            RST,
  addsub_pg_pipe_if.slave io
);
  localparam int LEVELS = $clog2(WIDTH);

  logic take1, take2, take3;
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] s_sum;

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic             c0_1_q, c0_1_d;

  logic             v2_q, v2_d;
  logic [WIDTH-1:0] p2_q, p2_d;
  logic [WIDTH:1]   c2_q, c2_d;
  logic             c0_2_q, c0_2_d;

  logic             v3_q, v3_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] gk [0:LEVELS];
  logic [WIDTH-1:0] pk [0:LEVELS-1];

  // A stage can take new content when empty or when its own content leaves this cycle.
  assign take3 = ~v3_q | io.out_ready;
  assign take2 = ~v2_q | take3;
  assign take1 = ~v1_q | take2;

  assign bb = io.B ^ {WIDTH{io.Sub}};

  // Carry-in folded into bit 0 so the prefix result at bit i is the carry into bit i+1.
  assign gk[0] = {g1_q[WIDTH-1:1], g1_q[0] | (p1_q[0] & c0_1_q)};
  assign pk[0] = p1_q;

  for (genvar l = 0; l < LEVELS; l++) begin : g_ks
    localparam int D = 1 << l;
    assign gk[l+1] = gk[l] | (pk[l] & (gk[l] << D));
    if (l < LEVELS - 1) begin : g_p
      assign pk[l+1] = pk[l] & ~(~pk[l] << D);
    end
  end

  assign s_sum = p2_q ^ {c2_q[WIDTH-1:1], c0_2_q};

  always_comb begin
    v1_d    = v1_q;
    p1_d    = p1_q;
    g1_d    = g1_q;
    c0_1_d  = c0_1_q;
    v2_d    = v2_q;
    p2_d    = p2_q;
    c2_d    = c2_q;
    c0_2_d  = c0_2_q;
    v3_d    = v3_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    if (take1) begin
      v1_d = io.in_valid;
      if (io.in_valid) begin
        p1_d   = io.A ^ bb;
        g1_d   = io.A & bb;
        c0_1_d = io.Sub;
      end
    end

    if (take2) begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d   = p1_q;
        c2_d   = gk[LEVELS];
        c0_2_d = c0_1_q;
      end
    end

    if (take3) begin
      v3_d = v2_q;
      if (v2_q) begin
        s_d     = s_sum;
        c_out_d = c2_q[WIDTH];
        ovf_d   = c2_q[WIDTH] ^ c2_q[WIDTH-1];
        zero_d  = ~|s_sum;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1_q    <= 1'b0;
      p1_q    <= '0;
      g1_q    <= '0;
      c0_1_q  <= 1'b0;
      v2_q    <= 1'b0;
      p2_q    <= '0;
      c2_q    <= '0;
      c0_2_q  <= 1'b0;
      v3_q    <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      p1_q    <= p1_d;
      g1_q    <= g1_d;
      c0_1_q  <= c0_1_d;
      v2_q    <= v2_d;
      p2_q    <= p2_d;
      c2_q    <= c2_d;
      c0_2_q  <= c0_2_d;
      v3_q    <= v3_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign io.in_ready  = take1;
  assign io.out_valid = v3_q;
  assign io.S         = s_q;
  assign io.C_OUT     = c_out_q;
  assign io.OVF       = ovf_q;
  assign io.ZERO      = zero_q;
endmodule

// File: tb/tb_addsub_pg_pipe.sv
// tb/tb_addsub_pg_pipe.sv - bench for addsub_pg_pipe at WIDTH 2, 8 and 64
`timescale 1ns/1ps
module tb_addsub_pg_pipe;
  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  addsub_pg_pipe_if #(.WIDTH(2))  b2  ();
  addsub_pg_pipe_if #(.WIDTH(8))  b8  ();
  addsub_pg_pipe_if #(.WIDTH(64)) b64 ();

  addsub_pg_pipe #(.WIDTH(2))  u_w2  (.CLK(CLK), .RST(RST), .io(b2.slave));
  addsub_pg_pipe #(.WIDTH(8))  u_w8  (.CLK(CLK), .RST(RST), .io(b8.slave));
  addsub_pg_pipe #(.WIDTH(64)) u_w64 (.CLK(CLK), .RST(RST), .io(b64.slave));

  int errors = 0;
  int checks = 0;
  res_t exp_q[$];
  logic [63:0] op_a[$];
  logic [63:0] op_b[$];
  logic        op_s[$];

  // Reference: plain integer arithmetic on widened values.
  function automatic res_t model(int w, logic [63:0] a, logic [63:0] b, logic sub);
    res_t r;
    logic [64:0] mask, wide;
    logic signed [66:0] sa, sb, sr, lim;
    mask = (65'd1 << w) - 65'd1;
    a = a & mask[63:0];
    b = b & mask[63:0];
    wide = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r.s = wide[63:0] & mask[63:0];
    r.c = sub ? (a >= b) : wide[w];
    lim = 67'sd1 <<< (w - 1);
    sa = $signed({3'b000, a});
    sb = $signed({3'b000, b});
    if (a[w-1]) sa = sa - (lim <<< 1);
    if (b[w-1]) sb = sb - (lim <<< 1);
    sr = sub ? (sa - sb) : (sa + sb);
    r.o = (sr >= lim) || (sr < -lim);
    r.z = (r.s == 64'd0);
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_res(string tag, res_t got, res_t expv);
    chk({tag, ".S"}, got.s, expv.s);
    chk({tag, ".C_OUT"}, 64'(got.c), 64'(expv.c));
    chk({tag, ".OVF"}, 64'(got.o), 64'(expv.o));
    chk({tag, ".ZERO"}, 64'(got.z), 64'(expv.z));
  endtask

  task automatic drive(int w, logic v, logic [63:0] a, logic [63:0] b, logic s, logic ordy);
    case (w)
      2: begin
        b2.in_valid = v; b2.A = a[1:0]; b2.B = b[1:0]; b2.Sub = s; b2.out_ready = ordy;
      end
      8: begin
        b8.in_valid = v; b8.A = a[7:0]; b8.B = b[7:0]; b8.Sub = s; b8.out_ready = ordy;
      end
      default: begin
        b64.in_valid = v; b64.A = a; b64.B = b; b64.Sub = s; b64.out_ready = ordy;
      end
    endcase
  endtask

  task automatic sample(int w, output logic ir, output logic ov, output res_t r);
    case (w)
      2: begin
        ir = b2.in_ready; ov = b2.out_valid; r.s = {62'd0, b2.S};
        r.c = b2.C_OUT; r.o = b2.OVF; r.z = b2.ZERO;
      end
      8: begin
        ir = b8.in_ready; ov = b8.out_valid; r.s = {56'd0, b8.S};
        r.c = b8.C_OUT; r.o = b8.OVF; r.z = b8.ZERO;
      end
      default: begin
        ir = b64.in_ready; ov = b64.out_valid; r.s = b64.S;
        r.c = b64.C_OUT; r.o = b64.OVF; r.z = b64.ZERO;
      end
    endcase
  endtask

  task automatic op8(logic [7:0] a, logic [7:0] b, logic s, logic [7:0] exp_s, string tag);
    logic ir, ov;
    res_t r;
    @(negedge CLK);
    drive(8, 1'b1, 64'(a), 64'(b), s, 1'b1);
    #1 sample(8, ir, ov, r);
    chk({tag, ".in_ready"}, 64'(ir), 64'd1);
    @(negedge CLK);
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    #1 sample(8, ir, ov, r);
    chk({tag, ".lat1_valid"}, 64'(ov), 64'd0);
    @(negedge CLK);
    #1 sample(8, ir, ov, r);
    chk({tag, ".lat2_valid"}, 64'(ov), 64'd0);
    @(negedge CLK);
    #1 sample(8, ir, ov, r);
    chk({tag, ".lat3_valid"}, 64'(ov), 64'd1);
    chk({tag, ".S_const"}, r.s, 64'(exp_s));
    chk_res(tag, r, model(8, 64'(a), 64'(b), s));
  endtask

  // Streams op_a/op_b/op_s through one DUT; out_ready is low for cycles stall_lo..stall_hi.
  task automatic run_stream(int w, int stall_lo, int stall_hi, string tag);
    int n, sent, acc_cnt, del, cyc;
    bit blocked_seen, prev_stall;
    logic ir, ov, ordy;
    res_t r, held;
    n = op_a.size();
    sent = 0; acc_cnt = 0; del = 0; cyc = 0;
    blocked_seen = 0; prev_stall = 0;
    exp_q.delete();
    while (del < n && cyc < n * 4 + 40) begin
      @(negedge CLK);
      ordy = !(cyc >= stall_lo && cyc <= stall_hi);
      if (sent < n) drive(w, 1'b1, op_a[sent], op_b[sent], op_s[sent], ordy);
      else          drive(w, 1'b0, 64'd0, 64'd0, 1'b0, ordy);
      #1 sample(w, ir, ov, r);
      if (prev_stall) begin
        chk({tag, ".stall_valid"}, 64'(ov), 64'd1);
        chk_res({tag, ".stall_hold"}, r, held);
      end
      if (stall_hi >= 0 && cyc > stall_hi) chk({tag, ".no_gap"}, 64'(ov), 64'd1);
      if (stall_hi >= 0 && !ir && !blocked_seen) begin
        blocked_seen = 1;
        chk({tag, ".in_flight_at_block"}, 64'(acc_cnt - del), 64'd3);
      end
      if (ov && ordy) begin
        chk({tag, ".word_expected"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk_res({tag, ".result"}, r, exp_q.pop_front());
        del++;
      end
      if (sent < n && ir) begin
        exp_q.push_back(model(w, op_a[sent], op_b[sent], op_s[sent]));
        sent++;
        acc_cnt++;
      end
      prev_stall = ov && !ordy;
      held = r;
      cyc++;
    end
    chk({tag, ".delivered_all"}, 64'(del), 64'(n));
    if (stall_hi >= 0) chk({tag, ".block_seen"}, 64'(blocked_seen), 64'd1);
    @(negedge CLK);
    drive(w, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic ir, ov;
    res_t r, zr;
    zr = '{s: 64'd0, c: 1'b0, o: 1'b0, z: 1'b0};
    drive(2, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    drive(64, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);

    #1 RST = 1'b1;
    #2;
    sample(2, ir, ov, r);  chk("reset_w2.valid", 64'(ov), 64'd0);  chk_res("reset_w2", r, zr);
    sample(8, ir, ov, r);  chk("reset_w8.valid", 64'(ov), 64'd0);  chk_res("reset_w8", r, zr);
    sample(64, ir, ov, r); chk("reset_w64.valid", 64'(ov), 64'd0); chk_res("reset_w64", r, zr);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1 sample(8, ir, ov, r);
    chk("in_ready_after_reset", 64'(ir), 64'd1);

    op8(8'h7F, 8'h01, 1'b0, 8'h80, "add_7f_01");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, "add_ff_01");
    op8(8'h05, 8'h05, 1'b1, 8'h00, "sub_05_05");
    op8(8'h03, 8'h05, 1'b1, 8'hFE, "sub_03_05");
    op8(8'h80, 8'h01, 1'b1, 8'h7F, "sub_80_01");

    op_a.delete(); op_b.delete(); op_s.delete();
    for (int i = 0; i < 10; i++) begin
      op_a.push_back(64'($urandom_range(0, 255)));
      op_b.push_back(64'($urandom_range(0, 255)));
      op_s.push_back(i[0]);
    end
    run_stream(8, 4, 9, "w8_stream");

    @(negedge CLK); drive(8, 1'b1, 64'h11, 64'h22, 1'b0, 1'b0);
    @(negedge CLK); drive(8, 1'b1, 64'h33, 64'h44, 1'b1, 1'b0);
    @(negedge CLK); drive(8, 1'b1, 64'h55, 64'h66, 1'b0, 1'b0);
    @(negedge CLK); drive(8, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    #1 sample(8, ir, ov, r);
    chk("full.in_ready", 64'(ir), 64'd0);
    chk("full.out_valid", 64'(ov), 64'd1);
    #1 RST = 1'b1;
    #1 sample(8, ir, ov, r);
    chk("async_reset.valid", 64'(ov), 64'd0);
    chk("async_reset.in_ready", 64'(ir), 64'd1);
    chk_res("async_reset", r, zr);
    @(negedge CLK);
    RST = 1'b0;
    drive(8, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1 sample(8, ir, ov, r);
      chk("no_stale_after_reset", 64'(ov), 64'd0);
    end
    op8(8'h40, 8'h3F, 1'b0, 8'h7F, "post_reset");

    op_a.delete(); op_b.delete(); op_s.delete();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int s = 0; s < 2; s++) begin
          op_a.push_back(64'(a));
          op_b.push_back(64'(b));
          op_s.push_back(s[0]);
        end
    run_stream(2, -1, -1, "w2_exhaustive");

    op_a.delete(); op_b.delete(); op_s.delete();
    op_a.push_back(64'hFFFF_FFFF_FFFF_FFFF); op_b.push_back(64'd1); op_s.push_back(1'b0);
    op_a.push_back(64'd0);                   op_b.push_back(64'd1); op_s.push_back(1'b1);
    op_a.push_back(64'h7FFF_FFFF_FFFF_FFFF); op_b.push_back(64'd1); op_s.push_back(1'b0);
    op_a.push_back(64'h8000_0000_0000_0000); op_b.push_back(64'd1); op_s.push_back(1'b1);
    op_a.push_back(64'hFFFF_FFFF_FFFF_FFFF); op_b.push_back(64'hFFFF_FFFF_FFFF_FFFF); op_s.push_back(1'b1);
    for (int i = 0; i < 16; i++) begin
      op_a.push_back({$urandom, $urandom});
      op_b.push_back({$urandom, $urandom});
      op_s.push_back(1'($urandom_range(0, 1)));
    end
    run_stream(64, 5, 7, "w64_stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
